// File: rtl/mem_pkg.sv
// Shared encodings and byte-lane helpers for the data-memory stage.
// Access-size and direction codes match what the execute stage drives.
package mem_pkg;

    localparam logic [1:0] SEC_BYTE  = 2'b00;
    localparam logic [1:0] SEC_HALF  = 2'b01;
    localparam logic [1:0] SEC_WORD  = 2'b10;

    localparam logic       MEM_WRITE = 1'b0;
    localparam logic       MEM_READ  = 1'b1;

    // Byte enables within a 32-bit word. The low address bits that alignment
    // ignores are simply not looked at.
    function automatic logic [3:0] byte_enable(input logic [1:0] sec, input logic [1:0] off);
        logic [3:0] be;
        case (sec)
            SEC_BYTE: be = 4'b0001 << off;
            SEC_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store data so every enabled lane sees its own bytes.
    function automatic logic [31:0] store_lanes(input logic [1:0] sec, input logic [31:0] data);
        logic [31:0] lanes;
        case (sec)
            SEC_BYTE: lanes = {4{data[7:0]}};
            SEC_HALF: lanes = {2{data[15:0]}};
            default:  lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane from a raw memory word and
// sign-extends it to 32 bits.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  off,
    input  logic [1:0]  sec,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[7:0];
        case (off)
            2'd0: byte_sel = raw[7:0];
            2'd1: byte_sel = raw[15:8];
            2'd2: byte_sel = raw[23:16];
            2'd3: byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
        half_sel = off[1] ? raw[31:16] : raw[15:0];

        case (sec)
            SEC_BYTE: data = {{24{byte_sel[7]}}, byte_sel};
            SEC_HALF: data = {{16{half_sel[15]}}, half_sel};
            default:  data = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Data-memory pipeline stage: little-endian byte-lane RAM with byte/half/word
// stores and a registered, sign-extended load result aligned with the ALU result.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRW,
    input  logic [1:0]  dataSec_i,
    input  logic [31:0] dataW_i,
    input  logic [31:0] addr_i,
    output logic [31:0] alu_o,
    output logic [31:0] data_o
);

    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

    logic [ADDR_WIDTH-1:0] ea;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [3:0]            be;
    logic [3:0][7:0]       wr_lanes;
    logic [31:0]           raw_word;
    logic [31:0]           load_data;

    // Word-granular storage with per-lane enables; alignment never lets an
    // access straddle two words, so one row read covers every size.
    logic [3:0][7:0] mem [WORDS];

    assign ea       = addr_i[ADDR_WIDTH-1:0];
    assign word_idx = ea[ADDR_WIDTH-1:2];
    assign be       = byte_enable(dataSec_i, ea[1:0]);
    assign wr_lanes = store_lanes(dataSec_i, dataW_i);
    assign raw_word = mem[word_idx];

    // Memory is deliberately not reset; reset only blocks new stores.
    always_ff @(posedge clk) begin
        if (!rst && memRW == MEM_WRITE) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) mem[word_idx][l] <= wr_lanes[l];
            end
        end
    end

    load_extend u_load_extend (
        .raw  (raw_word),
        .off  (ea[1:0]),
        .sec  (dataSec_i),
        .data (load_data)
    );

    // Captured every cycle; on a store this holds the pre-store contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_o  <= '0;
            data_o <= '0;
        end else begin
            alu_o  <= addr_i;
            data_o <= load_data;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset corner sequences and a
// randomized run against a byte-array reference model.
module tb_mem_stage;

    localparam int AW        = 11;
    localparam int MEM_BYTES = 1 << AW;

    logic        clk;
    logic        rst;
    logic        memRW;
    logic [1:0]  dataSec_i;
    logic [31:0] dataW_i;
    logic [31:0] addr_i;
    logic [31:0] alu_o;
    logic [31:0] data_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .memRW     (memRW),
        .dataSec_i (dataSec_i),
        .dataW_i   (dataW_i),
        .addr_i    (addr_i),
        .alu_o     (alu_o),
        .data_o    (data_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] mdl_mem   [MEM_BYTES];
    bit         mdl_known [MEM_BYTES];

    function automatic int size_bytes(input logic [1:0] sec);
        if (sec == 2'b00) return 1;
        if (sec == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int base_addr(input logic [1:0] sec, input logic [31:0] addr);
        int ea;
        int n;
        ea = int'(addr % MEM_BYTES);
        n  = size_bytes(sec);
        return ea - (ea % n);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sec, input logic [31:0] addr,
                                               output bit ok);
        longint val;
        int     n;
        int     b;
        n   = size_bytes(sec);
        b   = base_addr(sec, addr);
        val = 0;
        ok  = 1;
        for (int i = 0; i < n; i++) begin
            val = val + longint'(mdl_mem[b + i]) * (longint'(1) << (8 * i));
            if (!mdl_known[b + i]) ok = 0;
        end
        if (n < 4 && val >= (longint'(1) << (8 * n - 1)))
            val = val - (longint'(1) << (8 * n));
        return val[31:0];
    endfunction

    task automatic model_store(input logic [1:0] sec, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        int b;
        logic [31:0] d;
        n = size_bytes(sec);
        b = base_addr(sec, addr);
        d = wd;
        for (int i = 0; i < n; i++) begin
            mdl_mem[b + i]   = d[7:0];
            mdl_known[b + i] = 1;
            d = d >> 8;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
        n_checks++;
        if (act === bad) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected anything but 0x%08h", name, act, bad);
        end
    endtask

    // ---------------- driver ----------------
    // Presents one request for a cycle and returns the registered outputs after the edge.
    task automatic op(input logic r, input logic rw, input logic [1:0] sec, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] d, output logic [31:0] a);
        rst       = r;
        memRW     = rw;
        dataSec_i = sec;
        addr_i    = addr;
        dataW_i   = wd;
        @(posedge clk);
        #1;
        d = data_o;
        a = alu_o;
        if (!r && !rw) model_store(sec, addr, wd);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rw;
        logic [1:0]  sec;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rw, input logic [1:0] sec, input logic [31:0] addr,
                       input logic [31:0] wd, input logic chk, input logic [31:0] exp, input string name);
        vec_t v;
        v.rw = rw; v.sec = sec; v.addr = addr; v.wd = wd; v.chk = chk; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] exp;
        logic [31:0] addr;
        logic [1:0]  sec;
        logic        rw;
        bit          ok;

        for (int i = 0; i < MEM_BYTES; i++) begin
            mdl_mem[i]   = 8'h00;
            mdl_known[i] = 0;
        end

        rst = 1'b1; memRW = 1'b0; dataSec_i = 2'b10; addr_i = '0; dataW_i = 32'h12345678;

        // Reset held with a store pending: outputs zero, store suppressed.
        for (int c = 0; c < 2; c++) begin
            op(1'b1, 1'b0, 2'b10, 32'h0, 32'h12345678, d, a);
            check("rst_data", d, 32'h0);
            check("rst_alu", a, 32'h0);
        end
        op(1'b0, 1'b1, 2'b10, 32'h0, 32'h0, d, a);
        check_ne("rst_store_suppressed", d, 32'h12345678);
        check("rst_release_alu", a, 32'h0);

        add(1'b0, 2'b10, 32'h0,        32'hAAAAAAAA, 1'b0, 32'h0,        "st_w0");
        add(1'b1, 2'b10, 32'h0,        32'h0,        1'b1, 32'hAAAAAAAA, "ld_w0");
        add(1'b1, 2'b00, 32'h1,        32'h0,        1'b1, 32'hFFFFFFAA, "ld_b1");
        add(1'b1, 2'b01, 32'h2,        32'h0,        1'b1, 32'hFFFFAAAA, "ld_h2");
        add(1'b0, 2'b10, 32'h4,        32'h0,        1'b0, 32'h0,        "st_w4");
        add(1'b0, 2'b01, 32'h4,        32'hBBBBBBBB, 1'b1, 32'h0,        "st_h4_old");
        add(1'b1, 2'b10, 32'h4,        32'h0,        1'b1, 32'h0000BBBB, "ld_w4");
        add(1'b1, 2'b01, 32'h6,        32'h0,        1'b1, 32'h00000000, "ld_h6");
        add(1'b0, 2'b10, 32'h8,        32'h11223344, 1'b0, 32'h0,        "st_w8");
        add(1'b0, 2'b00, 32'h8,        32'hCCCCCCCC, 1'b1, 32'h00000044, "st_b8_old");
        add(1'b1, 2'b10, 32'h8,        32'h0,        1'b1, 32'h112233CC, "ld_w8");
        add(1'b1, 2'b00, 32'h8,        32'h0,        1'b1, 32'hFFFFFFCC, "ld_b8");
        add(1'b1, 2'b00, 32'h9,        32'h0,        1'b1, 32'h00000033, "ld_b9");
        add(1'b1, 2'b11, 32'h8,        32'h0,        1'b1, 32'h112233CC, "ld_sec11");
        add(1'b1, 2'b10, 32'hFFFFF808, 32'h0,        1'b1, 32'h112233CC, "ld_upper_ign");
        add(1'b1, 2'b10, 32'h800,      32'h0,        1'b1, 32'hAAAAAAAA, "ld_wrap800");
        add(1'b1, 2'b10, 32'h3,        32'h0,        1'b1, 32'hAAAAAAAA, "ld_w3_align");
        add(1'b1, 2'b01, 32'h7,        32'h0,        1'b1, 32'h00000000, "ld_h7_align");
        add(1'b0, 2'b10, 32'h10,       32'h01020304, 1'b0, 32'h0,        "st_w10_pre");
        add(1'b0, 2'b10, 32'h10,       32'hDEADBEEF, 1'b1, 32'h01020304, "st_w10_old");
        add(1'b1, 2'b10, 32'h10,       32'h0,        1'b1, 32'hDEADBEEF, "ld_b2b");

        foreach (vecs[i]) begin
            op(1'b0, vecs[i].rw, vecs[i].sec, vecs[i].addr, vecs[i].wd, d, a);
            check({vecs[i].name, "_alu"}, a, vecs[i].addr);
            if (vecs[i].chk) check(vecs[i].name, d, vecs[i].exp);
        end

        // Mid-operation reset: outputs clear, stored data survives, store blocked.
        op(1'b1, 1'b0, 2'b00, 32'h0, 32'h00000055, d, a);
        check("midrst_data", d, 32'h0);
        check("midrst_alu", a, 32'h0);
        op(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, d, a);
        check("midrst_preserve_b0", d, 32'hFFFFFFAA);
        op(1'b0, 1'b1, 2'b10, 32'h10, 32'h0, d, a);
        check("midrst_preserve_w10", d, 32'hDEADBEEF);

        // Randomized traffic over a small window (with random upper bits) to force reuse.
        for (int i = 0; i < 600; i++) begin
            rw   = ($urandom_range(0, 1) == 0);
            sec  = 2'($urandom_range(0, 3));
            addr = ($urandom_range(0, 63)) | ($urandom_range(0, 1) ? ($urandom() & 32'hFFFFF800) : 32'h0);
            exp  = model_load(sec, addr, ok);
            op(1'b0, rw, sec, addr, $urandom(), d, a);
            check("rnd_alu", a, addr);
            if (ok) check("rnd_data", d, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
